// File: rtl/cpu_timing_gen_pkg.sv
// Shared constants for the CPU timing generator: data width, T-state indices
// and the FSM state encoding.
package cpu_timing_gen_pkg;

    localparam int DATA_WIDTH = 8;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_timing_gen_edge_detect.sv
// Rising-edge pulse generator with synchronous active-high reset; the pulse is
// combinational from the live input, so it is valid in the same cycle.
module cpu_timing_gen_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset)
            sig_q <= 1'b0;
        else
            sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/cpu_timing_gen.sv
// One-hot T-state sequencer for the control unit: free-run, single-step,
// sticky halt, and early end-of-instruction.
module cpu_timing_gen
    import cpu_timing_gen_pkg::*;
#(
    parameter int NUM_STATES = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          step,
    input  logic                          halt,
    input  logic                          end_instr,
    output logic [NUM_STATES-1:0]         tstate,
    output logic [$clog2(NUM_STATES)-1:0] tcount,
    output logic                          instr_start,
    output logic                          halted,
    output logic [CNT_WIDTH-1:0]          instr_count
);

    localparam int TW = $clog2(NUM_STATES);
    localparam logic [TW-1:0] LAST = TW'(NUM_STATES - 1);

    state_t          state;
    logic            step_rise;
    logic            advance;
    logic            wrap;
    logic [TW-1:0]   tcount_nxt;
    logic [NUM_STATES-1:0] tstate_nxt;

    cpu_timing_gen_edge_detect u_step_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (step),
        .rise  (step_rise)
    );

    // run has priority over a coincident step edge while paused
    always_comb begin
        advance    = (state == S_RUN) | ((state == S_PAUSE) & step_rise & ~run);
        wrap       = end_instr | (tcount == LAST);
        tcount_nxt = tcount;
        if (advance)
            tcount_nxt = wrap ? '0 : tcount + TW'(1);
        tstate_nxt = '0;
        tstate_nxt[tcount_nxt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_PAUSE;
            tcount      <= '0;
            tstate      <= NUM_STATES'(1);
            instr_start <= 1'b1;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (advance) begin
                tcount      <= tcount_nxt;
                tstate      <= tstate_nxt;
                instr_start <= (tcount_nxt == '0);
                if (wrap)
                    instr_count <= instr_count + CNT_WIDTH'(1);
            end

            if (advance & halt) begin
                state  <= S_HALT;
                halted <= 1'b1;
            end else begin
                case (state)
                    S_PAUSE: if (run)  state <= S_RUN;
                    S_RUN:   if (!run) state <= S_PAUSE;
                    S_HALT:  state <= S_HALT;
                    default: state <= S_PAUSE;
                endcase
            end
        end
    end

endmodule

// File: doc/cpu_timing_gen.md
Name: cpu_timing_gen

Overview:
Downstream of clk_divider. Runs on the divided CPU clock and produces the one-hot T-state timing the control unit decodes each micro-step. Supports free-run, single-step, and a sticky halt. Variable-length instructions are supported through an early end-of-instruction input from the control unit.

Parameters:
NUM_STATES, 6, number of T-states per instruction (T0..T(NUM_STATES-1)); minimum 2
CNT_WIDTH, 8, width of the retired-instruction counter

Ports:
clk  input  1  CPU clock (clk_out of clk_divider)
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = free-run, 0 = paused
step  input  1  single-step request; the rising edge is detected internally
halt  input  1  HLT decode from the control unit
end_instr  input  1  current T-state is the last of this instruction
tstate  output  NUM_STATES  one-hot T-state, registered
tcount  output  $clog2(NUM_STATES)  binary T-state index, registered
instr_start  output  1  high while tcount==0
halted  output  1  high in S_HALT
instr_count  output  CNT_WIDTH  instructions retired (wraps)

Behaviour:
- Every listed behaviour is decided; all state updates happen on posedge clk.
- Reset is synchronous, active-high and has priority over all other inputs. On reset:
  - tcount=0, tstate=1 (T0), instr_start=1, halted=0, instr_count=0.
  - FSM state = S_PAUSE.
  - step edge register = 0.
- FSM states: S_PAUSE, S_RUN, S_HALT.
  - S_PAUSE -> S_RUN when run=1.
  - S_RUN -> S_PAUSE when run=0.
  - S_PAUSE or S_RUN -> S_HALT when halt=1 in a cycle where advance=1.
  - S_HALT exits only via reset.
- step_rise = step & ~step_q, where step_q is step registered every cycle.
- advance = (state==S_RUN) | (state==S_PAUSE & step_rise & ~run).
  - When run and step_rise coincide in S_PAUSE, run wins. No step advance occurs; the FSM enters S_RUN.
  - The first run advance happens in the cycle after S_RUN is entered.
- On advance:
  - If end_instr=1 or tcount==NUM_STATES-1: tcount <= 0 and instr_count <= instr_count+1 (modulo 2^CNT_WIDTH).
  - Otherwise tcount <= tcount+1.
- With no advance, tcount, tstate and instr_count hold. end_instr is ignored in that cycle.
- halt:
  - The advance in the cycle where halt is sampled completes, including a wrap and its count.
  - tstate then freezes and halted=1 from the next cycle.
  - halt sampled while not advancing has no effect.
- tstate is always the one-hot decode of tcount, held in a register, never glitching combinationally. Exactly one bit is set at all times.
- A step held high advances only once. A new advance needs a low-then-high transition.
- Reset mid-instruction abandons the instruction. instr_count does not increment for it.
- Latency: inputs sampled at edge N are reflected on the outputs after edge N.

Decomposition:
- Shared defines header: T-state index constants (T0..T5) and the FSM state encodings S_PAUSE, S_RUN, S_HALT, next to the existing DATA_WIDTH define.
- One sub-module: edge_detect, a rising-edge pulse generator for step with synchronous active-high reset. It is reusable for front-panel buttons.

Test Plan:
1. Reset, then run=1, end_instr=0 for 13 cycles -> FSM enters S_RUN on the first edge. Over the next 12 edges tstate goes 000010, 000100, 001000, 010000, 100000, 000001, repeated twice. instr_count=2.
2. Run, end_instr=1 while tcount==3 -> next tcount=0, tstate=000001, instr_count+1. T4 and T5 never appear.
3. run=0, step held high 5 cycles -> exactly one advance, tcount 0->1. Drop step for 1 cycle, raise again -> tcount=2. step and run raised together in S_PAUSE -> no step advance, then free-run.
4. Running, halt=1 at tcount==2 -> tcount=3 and halted=1 next cycle. Toggling run and step for 10 cycles leaves tcount=3. Reset -> tcount=0, halted=0, S_PAUSE.
5. reset=1 at tcount==4 with run=1, instr_count=7 -> next cycle tcount=0, instr_count=0, S_PAUSE. Release reset -> S_RUN, then advances resume.
6. CNT_WIDTH=4, run 16 full instructions of NUM_STATES each -> instr_count wraps 15->0. tstate stays one-hot throughout; the bench asserts this every cycle.
